fpu_result_buffer: RTL and testbench
====================================

// Module: fpu_result_buffer
// PURPOSE
//  Receiving end of the FPU result interface: captures every valid/result/trans_id/exception beat from the FPU wrapper
//  (valid-only, no backpressure) into an in-order FIFO and drains it to the FP writeback port using a valid/ready handshake.
//  Issues credits to the issue stage so the number of in-flight FPU ops plus buffered results never exceeds DEPTH.
//  Sits between the FPU wrapper outputs and the scoreboard FP writeback port.
// PARAMETERS
//  DEPTH       4   result entries, power of two, >=2
//  CNT_W       $clog2(DEPTH)+1   occupancy/in-flight counter width (derived, do not override)
// PORTS
//  clk_i          in   1              clock
//  rst_ni         in   1              asynchronous active-low reset
//  flush_i        in   1              pipeline flush; kills in-flight and buffered results
//  fpu_issue_i    in   1              an op handshakes into the FPU this cycle (fpu_valid_i & fpu_ready_o)
//  fpu_credit_o   out  1              issue stage may issue an FPU op this cycle
//  fpu_valid_i    in   1              result beat from the FPU
//  fpu_trans_id_i in   TRANS_ID_BITS  result transaction id
//  fpu_result_i   in   FLEN           result data
//  fpu_exception_i in  exception_t    result exception
//  wb_valid_o     out  1              head entry valid toward writeback
//  wb_ready_i     in   1              writeback accepts head entry
//  wb_trans_id_o  out  TRANS_ID_BITS  head trans_id
//  wb_result_o    out  FLEN           head result
//  wb_exception_o out  exception_t    head exception
//  err_o          out  1              sticky protocol error (overflow or unsolicited result)
// BEHAVIOUR
//  - Reset: count=0, inflight=0, rd/wr ptr=0, wb_valid_o=0, err_o=0, fpu_credit_o=1; data outputs don't-care (drive '0).
//  - Credit: fpu_credit_o = (inflight + count) < DEPTH, combinational on registered state only (no input paths).
//  - inflight: +1 on fpu_issue_i, -1 on fpu_valid_i; both same cycle -> unchanged.
//  - Push on fpu_valid_i: write entry at wr_ptr, wr_ptr wraps modulo DEPTH; count+1.
//  - Pop on wb_valid_o & wb_ready_i: rd_ptr wraps modulo DEPTH; count-1. Push+pop same cycle -> count unchanged, legal when full.
//  - Order: strict FIFO; trans_id never reordered. Latency push->wb_valid_o: 1 cycle (registered entry).
//  - wb_* stable while wb_valid_o & !wb_ready_i.
//  - Full (count==DEPTH) and push without pop: entry dropped, err_o<=1. fpu_valid_i while inflight==0 and !fpu_issue_i:
//    err_o<=1, beat still buffered if room. err_o clears only on reset.
//  - fpu_issue_i while fpu_credit_o==0: err_o<=1, inflight still increments (saturate at 2**CNT_W-1).
//  - flush_i (priority over all): next cycle count=0, inflight=0, ptrs=0, wb_valid_o=0; same-cycle push/issue/pop discarded.
//  - Reset asserted mid-operation: all state returns to reset values asynchronously; no partial writebacks.
// CONFIGURATION
//  FPU_RESULT_BYPASS_EN defined: when count==0 and fpu_valid_i, beat presented on wb_* combinationally same cycle;
//    if wb_ready_i also 1 it is consumed without being written (count unchanged). Flush cycle suppresses bypass.
//  Not defined: every result is written first, wb_valid_o earliest one cycle after fpu_valid_i; no input->output paths.
//  Credit formula identical in both builds.
// STRUCTURE
//  - Use ariane_pkg exception_t, TRANS_ID_BITS, FLEN; add fpu_wb_entry_t {trans_id, result, ex} to ariane_pkg.
//  - One sub-module: fpu_result_fifo (storage, ptrs, count; push/pop/flush/full/empty); credit, inflight, error, bypass
//    logic in the top. Empty when FP_PRESENT==0: outputs tied to reset values.
// TESTING
//  - Reset then idle: fpu_credit_o=1, wb_valid_o=0, err_o=0 for 10 cycles.
//  - Issue 4 ops (DEPTH=4), wb_ready_i=0 -> credit drops to 0 after 4th issue; return ids 3,7,1,5 -> wb presents 3,7,1,5
//    in order after wb_ready_i=1, one per cycle, credit back to 1 after first pop.
//  - Full buffer, push+pop same cycle -> count stays 4, no err_o, popped id is oldest.
//  - 2 inflight + 2 buffered, flush_i one cycle -> next cycle wb_valid_o=0, credit=1; late result beat -> err_o=1.
//  - Issue with credit=0 -> err_o=1; unsolicited fpu_valid_i with inflight=0 -> err_o=1.
//  - BYPASS_EN: empty, fpu_valid_i id=9 with wb_ready_i=1 -> wb_valid_o=1, id 9 same cycle, count stays 0; without macro: next cycle.

Source files
------------

// File: rtl/fpu_result_buffer_pkg.sv
// Shared types for the FPU result buffer: exception payload, writeback entry and FPU config.
package fpu_result_buffer_pkg;

  localparam int unsigned TRANS_ID_BITS = 4;
  localparam int unsigned FLEN          = 64;
  localparam bit          FP_PRESENT    = 1'b1;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [FLEN-1:0]          result;
    exception_t               ex;
  } fpu_wb_entry_t;

endpackage

// File: rtl/fpu_result_buffer_fifo.sv
// In-order result storage: DEPTH registered entries with wrapping pointers and occupancy count.
module fpu_result_fifo
  import fpu_result_buffer_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               push_i,
  input  logic               pop_i,
  input  fpu_wb_entry_t      data_i,
  output fpu_wb_entry_t      data_o,
  output logic [CNT_W-1:0]   count_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  fpu_wb_entry_t     mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              push_ok, pop_ok;

  assign empty_o = (count == '0);
  assign full_o  = (count == CNT_W'(DEPTH));
  assign count_o = count;

  // A push into a full FIFO only lands if the head leaves in the same cycle.
  assign pop_ok  = pop_i & ~empty_o & ~flush_i;
  assign push_ok = push_i & (~full_o | pop_ok) & ~flush_i;

  assign data_o = empty_o ? '0 : mem[rd_ptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok && !pop_ok)      count <= count + CNT_W'(1);
      else if (!push_ok && pop_ok) count <= count - CNT_W'(1);
    end
  end

  // Payload storage carries no reset; unread entries are masked by empty_o.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/fpu_result_buffer.sv
// FPU result buffer: captures FPU result beats, drains them in order to FP writeback, issues credits.
// Optional macro FPU_RESULT_BYPASS_EN presents a beat arriving at an empty buffer on wb_* in the same cycle.
module fpu_result_buffer
  import fpu_result_buffer_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     fpu_issue_i,
  output logic                     fpu_credit_o,
  input  logic                     fpu_valid_i,
  input  logic [TRANS_ID_BITS-1:0] fpu_trans_id_i,
  input  logic [FLEN-1:0]          fpu_result_i,
  input  exception_t               fpu_exception_i,
  output logic                     wb_valid_o,
  input  logic                     wb_ready_i,
  output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
  output logic [FLEN-1:0]          wb_result_o,
  output exception_t               wb_exception_o,
  output logic                     err_o
);

  if (FP_PRESENT) begin : gen_fp
    localparam logic [CNT_W-1:0] INFLIGHT_MAX = '1;

    fpu_wb_entry_t     in_entry, head, out_entry;
    logic [CNT_W-1:0]  inflight_q, inflight_d, count;
    logic [CNT_W:0]    occupancy;
    logic              full, empty, bypass, push, pop;
    logic              overflow, unsolicited, bad_issue, err_q;

    assign in_entry = '{trans_id: fpu_trans_id_i, result: fpu_result_i, ex: fpu_exception_i};

`ifdef FPU_RESULT_BYPASS_EN
    assign bypass = empty & fpu_valid_i & ~flush_i;
`else
    assign bypass = 1'b0;
`endif

    assign out_entry      = bypass ? in_entry : head;
    assign wb_valid_o     = ~empty | bypass;
    assign wb_trans_id_o  = out_entry.trans_id;
    assign wb_result_o    = out_entry.result;
    assign wb_exception_o = out_entry.ex;

    // A bypassed beat that is accepted right away never occupies storage.
    assign pop  = ~empty & wb_ready_i & ~flush_i;
    assign push = fpu_valid_i & ~(bypass & wb_ready_i) & ~flush_i;

    fpu_result_fifo #(.DEPTH(DEPTH)) i_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (flush_i),
      .push_i  (push),
      .pop_i   (pop),
      .data_i  (in_entry),
      .data_o  (head),
      .count_o (count),
      .full_o  (full),
      .empty_o (empty)
    );

    // Credit depends on registered state only, so there is no input-to-credit path.
    assign occupancy    = {1'b0, inflight_q} + {1'b0, count};
    assign fpu_credit_o = occupancy < (CNT_W+1)'(DEPTH);

    assign overflow    = push & full & ~pop;
    assign unsolicited = fpu_valid_i & (inflight_q == '0) & ~fpu_issue_i;
    assign bad_issue   = fpu_issue_i & ~fpu_credit_o;

    always_comb begin
      inflight_d = inflight_q;
      if (fpu_issue_i && !fpu_valid_i) begin
        if (inflight_q != INFLIGHT_MAX) inflight_d = inflight_q + CNT_W'(1);
      end else if (fpu_valid_i && !fpu_issue_i) begin
        if (inflight_q != '0) inflight_d = inflight_q - CNT_W'(1);
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        inflight_q <= '0;
        err_q      <= 1'b0;
      end else if (flush_i) begin
        inflight_q <= '0;
      end else begin
        inflight_q <= inflight_d;
        if (overflow || unsolicited || bad_issue) err_q <= 1'b1;
      end
    end

    assign err_o = err_q;
  end else begin : gen_no_fp
    assign fpu_credit_o   = 1'b1;
    assign wb_valid_o     = 1'b0;
    assign wb_trans_id_o  = '0;
    assign wb_result_o    = '0;
    assign wb_exception_o = '0;
    assign err_o          = 1'b0;
  end

endmodule

// File: tb/tb_fpu_result_buffer.sv
// Self-checking bench for fpu_result_buffer: directed scenarios plus randomized traffic vs a queue model.
module tb_fpu_result_buffer;
  import fpu_result_buffer_pkg::*;

  localparam int DEPTH = 4;
  localparam int INFLIGHT_MAX = 7;
`ifdef FPU_RESULT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic flush, issue, valid, ready;
  logic [TRANS_ID_BITS-1:0] id;
  logic [FLEN-1:0] res;
  exception_t ex;
  logic credit, wb_valid, err;
  logic [TRANS_ID_BITS-1:0] wb_id;
  logic [FLEN-1:0] wb_res;
  exception_t wb_ex;

  int checks = 0;
  int failures = 0;

  fpu_wb_entry_t q[$];
  int  m_inflight;
  bit  m_err;
  bit  ev, ec;
  fpu_wb_entry_t eh;

  always #5 clk = ~clk;

  fpu_result_buffer #(.DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush), .fpu_issue_i(issue),
    .fpu_credit_o(credit), .fpu_valid_i(valid), .fpu_trans_id_i(id),
    .fpu_result_i(res), .fpu_exception_i(ex), .wb_valid_o(wb_valid),
    .wb_ready_i(ready), .wb_trans_id_o(wb_id), .wb_result_o(wb_res),
    .wb_exception_o(wb_ex), .err_o(err)
  );

  function automatic fpu_wb_entry_t cur_entry();
    fpu_wb_entry_t e;
    e.trans_id = id;
    e.result   = res;
    e.ex       = ex;
    return e;
  endfunction

  // Expected outputs for the current model state and current inputs.
  function automatic void model_out(output bit v, output fpu_wb_entry_t h, output bit cr);
    v  = 1'b0;
    h  = '0;
    cr = (m_inflight + q.size()) < DEPTH;
    if (BYP && q.size() == 0 && valid && !flush) begin
      v = 1'b1;
      h = cur_entry();
    end else if (q.size() > 0) begin
      v = 1'b1;
      h = q[0];
    end
  endfunction

  function automatic void model_step();
    bit v, cr, bypassed, popped;
    fpu_wb_entry_t h;
    int n;
    model_out(v, h, cr);
    if (flush) begin
      q.delete();
      m_inflight = 0;
      return;
    end
    n = q.size();
    if (issue && !cr) m_err = 1'b1;
    if (valid && m_inflight == 0 && !issue) m_err = 1'b1;
    bypassed = BYP && n == 0 && valid && ready;
    popped   = v && ready && !bypassed;
    if (popped) void'(q.pop_front());
    if (valid && !bypassed) begin
      if (n < DEPTH || popped) q.push_back(cur_entry());
      else m_err = 1'b1;
    end
    m_inflight = m_inflight + int'(issue) - int'(valid);
    if (m_inflight < 0) m_inflight = 0;
    if (m_inflight > INFLIGHT_MAX) m_inflight = INFLIGHT_MAX;
  endfunction

  task automatic clear_inputs();
    flush = 0; issue = 0; valid = 0; ready = 0;
    id = '0; res = '0; ex = '0;
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_ni = 1'b0;
    q.delete();
    m_inflight = 0;
    m_err = 1'b0;
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
  endtask

  task automatic beat(input int tid);
    valid = 1;
    id = TRANS_ID_BITS'(tid);
    res = {$urandom, $urandom};
    ex = '{cause: 64'(tid), tval: {$urandom, $urandom}, valid: tid[0]};
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++;
      if ({credit, wb_valid, err} !== 3'b100)
        begin failures++; $display("FAIL reset_idle cyc=%0d credit/valid/err got=%b exp=100", c, {credit, wb_valid, err}); end
      tick();
    end
    issue = 1; tick();
    issue = 0; beat(6); tick();
    clear_inputs();
    #3 rst_ni = 1'b0;
    #1;
    checks++;
    if ({credit, wb_valid, err} !== 3'b100)
      begin failures++; $display("FAIL reset_async credit/valid/err got=%b exp=100", {credit, wb_valid, err}); end
    do_reset();
  endtask

  task automatic test_order();
    int exp_ids[4] = '{3, 7, 1, 5};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      issue = 1; #1;
      checks++;
      if (credit !== 1'b1) begin failures++; $display("FAIL order_credit_pre i=%0d got=%b exp=1", i, credit); end
      tick();
    end
    issue = 0;
    for (int i = 0; i < 4; i++) begin
      beat(exp_ids[i]); #1;
      checks++;
      if (credit !== 1'b0) begin failures++; $display("FAIL order_credit_full i=%0d got=%b exp=0", i, credit); end
      tick();
    end
    clear_inputs();
    ready = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (wb_valid !== 1'b1 || wb_id !== TRANS_ID_BITS'(exp_ids[k]))
        begin failures++; $display("FAIL order_head k=%0d got v=%b id=%0d exp v=1 id=%0d", k, wb_valid, wb_id, exp_ids[k]); end
      checks++;
      if (credit !== (k > 0)) begin failures++; $display("FAIL order_credit k=%0d got=%b exp=%b", k, credit, k > 0); end
      tick();
    end
    #1;
    checks++;
    if (wb_valid !== 1'b0 || err !== 1'b0)
      begin failures++; $display("FAIL order_drained got v=%b err=%b exp v=0 err=0", wb_valid, err); end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    issue = 1; repeat (4) tick();
    clear_inputs();
    for (int i = 0; i < 4; i++) begin beat(i); tick(); end
    clear_inputs();
    #1;
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL full_err_before got=%b exp=0", err); end
    beat(4); ready = 1; #1;
    checks++;
    if (wb_valid !== 1'b1 || wb_id !== TRANS_ID_BITS'(0))
      begin failures++; $display("FAIL full_pushpop_head got v=%b id=%0d exp v=1 id=0", wb_valid, wb_id); end
    tick();
    clear_inputs(); ready = 1;
    for (int k = 1; k <= 4; k++) begin
      #1;
      model_out(ev, eh, ec);
      checks++;
      if (wb_valid !== 1'b1 || wb_id !== TRANS_ID_BITS'(k) || {wb_id, wb_res, wb_ex} !== eh)
        begin failures++; $display("FAIL full_drain k=%0d got v=%b id=%0d exp v=1 id=%0d", k, wb_valid, wb_id, k); end
      tick();
    end
    #1;
    checks++;
    if (wb_valid !== 1'b0 || err !== m_err)
      begin failures++; $display("FAIL full_end got v=%b err=%b exp v=0 err=%b", wb_valid, err, m_err); end
  endtask

  task automatic test_flush();
    do_reset();
    issue = 1; repeat (4) tick();
    clear_inputs();
    beat(10); tick();
    beat(11); tick();
    clear_inputs();
    #1;
    checks++;
    if ({wb_valid, credit} !== 2'b10)
      begin failures++; $display("FAIL flush_pre valid/credit got=%b exp=10", {wb_valid, credit}); end
    flush = 1; beat(12); ready = 1; issue = 1; tick();
    clear_inputs(); #1;
    checks++;
    if ({wb_valid, credit, err} !== 3'b010)
      begin failures++; $display("FAIL flush_post valid/credit/err got=%b exp=010", {wb_valid, credit, err}); end
    beat(13); tick();
    clear_inputs(); #1;
    checks++;
    if (err !== 1'b1 || wb_valid !== 1'b1 || wb_id !== TRANS_ID_BITS'(13))
      begin failures++; $display("FAIL flush_late got err=%b v=%b id=%0d exp err=1 v=1 id=13", err, wb_valid, wb_id); end
  endtask

  task automatic test_errors();
    do_reset();
    issue = 1; repeat (4) tick();
    #1;
    checks++;
    if ({credit, err} !== 2'b00) begin failures++; $display("FAIL err_nocredit_pre credit/err got=%b exp=00", {credit, err}); end
    tick();
    clear_inputs(); #1;
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL err_issue_nocredit got=%b exp=1", err); end
    do_reset();
    beat(2); #1;
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL err_unsol_pre got=%b exp=0", err); end
    tick();
    clear_inputs(); #1;
    checks++;
    if (err !== 1'b1 || wb_valid !== 1'b1 || wb_id !== TRANS_ID_BITS'(2))
      begin failures++; $display("FAIL err_unsolicited got err=%b v=%b id=%0d exp err=1 v=1 id=2", err, wb_valid, wb_id); end
  endtask

  task automatic test_bypass();
    do_reset();
    issue = 1; tick();
    clear_inputs();
    beat(9); ready = 1; #1;
    checks++;
    if (wb_valid !== BYP || (BYP && wb_id !== TRANS_ID_BITS'(9)))
      begin failures++; $display("FAIL bypass_same got v=%b id=%0d exp v=%b id=9", wb_valid, wb_id, BYP); end
    tick();
    valid = 0; #1;
    checks++;
    if (wb_valid !== !BYP || (!BYP && wb_id !== TRANS_ID_BITS'(9)))
      begin failures++; $display("FAIL bypass_next got v=%b id=%0d exp v=%b id=9", wb_valid, wb_id, !BYP); end
    tick();
    #1;
    checks++;
    if ({wb_valid, credit, err} !== 3'b010)
      begin failures++; $display("FAIL bypass_end valid/credit/err got=%b exp=010", {wb_valid, credit, err}); end
  endtask

  task automatic test_random();
    int tid;
    do_reset();
    for (int c = 0; c < 500; c++) begin
      clear_inputs();
      flush = ($urandom_range(0, 40) == 0);
      issue = ((m_inflight + q.size()) < DEPTH) && ($urandom_range(0, 1) == 1);
      if (m_inflight > 0 && $urandom_range(0, 2) != 0) begin
        tid = int'($urandom_range(0, 15));
        beat(tid);
      end
      ready = ($urandom_range(0, 2) != 0);
      #1;
      model_out(ev, eh, ec);
      checks++;
      if (wb_valid !== ev) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", c, wb_valid, ev); end
      checks++;
      if (credit !== ec) begin failures++; $display("FAIL rnd_credit cyc=%0d got=%b exp=%b", c, credit, ec); end
      checks++;
      if (err !== m_err) begin failures++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", c, err, m_err); end
      if (ev) begin
        checks++;
        if ({wb_id, wb_res, wb_ex} !== eh)
          begin failures++; $display("FAIL rnd_head cyc=%0d got=%h exp=%h", c, {wb_id, wb_res, wb_ex}, eh); end
      end
      tick();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    test_reset();
    test_order();
    test_full_push_pop();
    test_flush();
    test_bypass();
    test_random();
    test_errors();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
